// File: rtl/reg4_share_ctrl_pkg.sv
// Shared types and defaults for the round-robin shared-register controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg4_share_ctrl_pkg;

    // Controller states; the unused encoding 2'd3 is treated as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_NREQ  = 2;

endpackage

// File: rtl/reg4_share_ctrl_shared_reg.sv
// WIDTH-bit D register with synchronous load enable; sole owner of the shared value.
// Latency: d appears on q one clk after ld_en is sampled high.
// Backpressure: none; loads whenever ld_en is high.
module reg4_share_ctrl_shared_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage flops: clear on reset, capture d only when loading.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ld_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg4_share_ctrl.sv
// Round-robin arbiter sharing one register between NREQ writers plus an all-ones preset.
// Latency: request seen in IDLE at E0, q updated at E1, ack/set_ack high E1..E2 (3 cycles/write).
// Backpressure: req/set_req are level-held until acked; requests arriving while busy wait for IDLE.
module reg4_share_ctrl
    import reg4_share_ctrl_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    input  logic                  set_req,
    output logic [NREQ-1:0]       ack,
    output logic                  set_ack,
    output logic                  busy,
    output logic [IDXW-1:0]       gnt_id,
    output logic [WIDTH-1:0]      q
);

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   gnt_nxt;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   rr_nxt;
    logic              set_pending;
    logic              set_pending_nxt;
    logic              win_vld;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   cand;
    logic              ld_en;
    logic [WIDTH-1:0]  ld_dat;

    // Round-robin search: first active requester at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(rr_ptr) + i >= NREQ) begin
                cand = IDXW'(int'(rr_ptr) + i - NREQ);
            end else begin
                cand = IDXW'(int'(rr_ptr) + i);
            end
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state logic: preset beats writes in IDLE; pointer advances only after a write's ACK.
    always_comb begin
        state_nxt       = state;
        gnt_nxt         = gnt_id;
        rr_nxt          = rr_ptr;
        set_pending_nxt = set_pending;
        case (state)
            IDLE: begin
                if (set_req) begin
                    set_pending_nxt = 1'b1;
                    state_nxt       = LOAD;
                end else if (win_vld) begin
                    gnt_nxt         = win_idx;
                    set_pending_nxt = 1'b0;
                    state_nxt       = LOAD;
                end
            end
            LOAD: begin
                state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
                if (!set_pending) begin
                    rr_nxt = (gnt_id == IDXW'(NREQ - 1)) ? '0 : gnt_id + IDXW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any in-flight write without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt_id      <= '0;
            rr_ptr      <= '0;
            set_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt_id      <= gnt_nxt;
            rr_ptr      <= rr_nxt;
            set_pending <= set_pending_nxt;
        end
    end

    // Load data: all ones for a preset, otherwise the granted requester's slice.
    always_comb begin
        ld_en  = (state == LOAD);
        ld_dat = '1;
        if (!set_pending) begin
            ld_dat = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_id == IDXW'(i)) begin
                    ld_dat = wr_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Handshake outputs decoded purely from registered state.
    always_comb begin
        busy    = (state == LOAD) || (state == ACK);
        set_ack = (state == ACK) && set_pending;
        ack     = '0;
        if ((state == ACK) && !set_pending) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_id == IDXW'(i)) begin
                    ack[i] = 1'b1;
                end
            end
        end
    end

    reg4_share_ctrl_shared_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .ld_en (ld_en),
        .d     (ld_dat),
        .q     (q)
    );

endmodule

// File: tb/tb_reg4_share_ctrl.sv
// Directed bench for reg4_share_ctrl: a 2-requester instance plus a 4-requester wrap instance.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk.
// Backpressure: requesters hold req until ack and drop it the cycle after.
module tb_reg4_share_ctrl;

    logic        clk;
    logic        reset;

    logic [1:0]  req;
    logic [7:0]  wr_data;
    logic        set_req;
    logic [1:0]  ack;
    logic        set_ack;
    logic        busy;
    logic [0:0]  gnt_id;
    logic [3:0]  q;

    logic [3:0]  req4;
    logic [15:0] wr_data4;
    logic        set_req4;
    logic [3:0]  ack4;
    logic        set_ack4;
    logic        busy4;
    logic [1:0]  gnt_id4;
    logic [3:0]  q4;

    int checks;
    int failures;

    reg4_share_ctrl #(.NREQ(2), .WIDTH(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_data (wr_data),
        .set_req (set_req),
        .ack     (ack),
        .set_ack (set_ack),
        .busy    (busy),
        .gnt_id  (gnt_id),
        .q       (q)
    );

    reg4_share_ctrl #(.NREQ(4), .WIDTH(4)) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .req     (req4),
        .wr_data (wr_data4),
        .set_req (set_req4),
        .ack     (ack4),
        .set_ack (set_ack4),
        .busy    (busy4),
        .gnt_id  (gnt_id4),
        .q       (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] g;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = '0;
        wr_data  = '0;
        set_req  = 1'b0;
        req4     = '0;
        wr_data4 = 16'h4321;
        set_req4 = 1'b0;
        tick();
        tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_set_ack", 32'(set_ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt", 32'(gnt_id), 32'h0);
        reset = 1'b0;
        tick();

        // Reset mid-LOAD discards the write
        req     = 2'b01;
        wr_data = 8'h0A;
        tick();
        chk("midld_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("midld_rst_busy", 32'(busy), 32'h0);
        chk("midld_rst_q", 32'(q), 32'h0);
        tick();
        chk("midld_rst_ack", 32'(ack), 32'h0);
        chk("midld_rst_q2", 32'(q), 32'h0);
        reset = 1'b0;
        tick();
        chk("midld_re_busy", 32'(busy), 32'h1);
        chk("midld_re_q_e0", 32'(q), 32'h0);
        tick();
        chk("midld_re_q", 32'(q), 32'hA);
        chk("midld_re_ack", 32'(ack), 32'h1);
        req = 2'b00;
        tick();
        chk("midld_re_ack_end", 32'(ack), 32'h0);
        chk("midld_re_idle", 32'(busy), 32'h0);

        // Single write from requester 1
        req     = 2'b10;
        wr_data = 8'h5A;
        tick();
        chk("single_gnt", 32'(gnt_id), 32'h1);
        chk("single_busy0", 32'(busy), 32'h1);
        chk("single_q_hold", 32'(q), 32'hA);
        tick();
        chk("single_busy1", 32'(busy), 32'h1);
        chk("single_q", 32'(q), 32'h5);
        chk("single_ack", 32'(ack), 32'h2);
        req = 2'b00;
        tick();
        chk("single_ack_end", 32'(ack), 32'h0);
        chk("single_busy_end", 32'(busy), 32'h0);

        // Contention: alternate 0,1,0,1 with q 3,C,3,C
        wr_data = 8'hC3;
        req     = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 2'd0 : 2'd1;
            tick();
            chk("cont_gnt", 32'(gnt_id), 32'(g));
            chk("cont_ack_ld", 32'(ack), 32'h0);
            tick();
            chk("cont_q", 32'(q), (g == 2'd0) ? 32'h3 : 32'hC);
            chk("cont_ack", 32'(ack), (g == 2'd0) ? 32'h1 : 32'h2);
            req[g[0]] = 1'b0;
            tick();
            chk("cont_ack_end", 32'(ack), 32'h0);
            req[g[0]] = 1'b1;
        end
        req = 2'b00;
        tick();

        // Preset wins over a simultaneous write, pointer unaffected
        wr_data = 8'h03;
        set_req = 1'b1;
        req     = 2'b01;
        tick();
        chk("preset_busy", 32'(busy), 32'h1);
        tick();
        chk("preset_q", 32'(q), 32'hF);
        chk("preset_set_ack", 32'(set_ack), 32'h1);
        chk("preset_ack", 32'(ack), 32'h0);
        set_req = 1'b0;
        tick();
        chk("preset_set_ack_end", 32'(set_ack), 32'h0);
        chk("preset_gnt_hold", 32'(gnt_id), 32'h1);
        tick();
        chk("preset_then_gnt", 32'(gnt_id), 32'h0);
        tick();
        chk("preset_then_q", 32'(q), 32'h3);
        chk("preset_then_ack", 32'(ack), 32'h1);
        req = 2'b00;
        tick();

        // Late drop: req falls during LOAD, write still commits
        wr_data = 8'h06;
        req     = 2'b01;
        tick();
        chk("late_busy", 32'(busy), 32'h1);
        req = 2'b00;
        tick();
        chk("late_q", 32'(q), 32'h6);
        chk("late_ack", 32'(ack), 32'h1);
        tick();
        chk("late_ack_end", 32'(ack), 32'h0);
        tick();
        chk("late_ack_once", 32'(ack), 32'h0);
        chk("late_idle", 32'(busy), 32'h0);

        // Pointer wrap on the 4-requester instance: order 3,0,1,2
        req4 = 4'b1000;
        tick();
        chk("wrap_gnt3", 32'(gnt_id4), 32'h3);
        tick();
        chk("wrap_q3", 32'(q4), 32'h4);
        chk("wrap_ack3", 32'(ack4), 32'h8);
        req4 = 4'b1111;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wrap_gnt", 32'(gnt_id4), 32'(k));
            tick();
            chk("wrap_q", 32'(q4), 32'(k + 1));
            chk("wrap_ack", 32'(ack4), 32'(1 << k));
            tick();
        end
        req4 = 4'b0000;
        tick();
        chk("wrap_idle", 32'(busy4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
